vga_fb_arbiter: RTL and testbench

Shares one single-port framebuffer SRAM between VGA scan-out and a host (CPU or blitter) port. It sits beside the 640x480 h/v sync generator and consumes its `h_count`, `v_count` and `display_en`. It reserves one fetch slot per 8-pixel group for display prefetch, serialises the fetched 1 bpp word into a pixel stream, and grants every other memory cycle to the host through a request/grant handshake.

---
 rtl/vga_fb_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: one display prefetch slot per 8-pixel group, host gets the rest.
// Optional VGA_FB_HOST_BLANK_ONLY_EN restricts host grants to blanking (display_en == 0).
module vga_fb_arbiter #(
  parameter int H_TOTAL        = 800,
  parameter int H_DISPLAY      = 640,
  parameter int V_TOTAL        = 525,
  parameter int V_DISPLAY      = 480,
  parameter int WORDS_PER_LINE = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        display_en,
  output logic        pixel_o,
  output logic        pixel_en_o,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_gnt,
  output logic [7:0]  host_rdata,
  output logic        host_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HD = 11'(H_DISPLAY);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [9:0]  VD = 10'(V_DISPLAY);

  if ((WORDS_PER_LINE != H_DISPLAY / 8) || (H_TOTAL % 8 != 0) || (H_DISPLAY % 8 != 0)) begin : g_cfg_err
    $error("vga_fb_arbiter: inconsistent line geometry parameters");
  end

  logic        host_gnt_q, host_gnt_d;
  logic [15:0] mem_addr_q;
  logic        mem_re_q, mem_we_q;
  logic [7:0]  mem_wdata_q;
  logic        is_disp_q;
  logic        disp_pend_q;
  logic        host_rvalid_q;
  logic [7:0]  hold_q;
  logic [7:0]  sr_q, sr_d;
  logic        pixel_q, pixel_en_q;

  logic [10:0] tx;
  logic [9:0]  ty;
  logic [15:0] ty16;
  logic [15:0] disp_addr;
  logic        disp_slot;
  logic        blank_ok;

  always_comb begin
    tx = {1'b0, h_count} + 11'd7;
    ty = v_count;
    if (tx >= HT) begin
      tx = tx - HT;
      ty = (ty + 10'd1 == VT) ? '0 : ty + 10'd1;
    end
    disp_slot = (h_count[2:0] == 3'd1) && (tx < HD) && (ty < VD);
    ty16      = {6'b0, ty};
    disp_addr = (ty16 << 6) + (ty16 << 4) + {8'b0, tx[10:3]};
`ifdef VGA_FB_HOST_BLANK_ONLY_EN
    blank_ok  = !display_en;
`else
    blank_ok  = 1'b1;
`endif
    host_gnt_d = host_req && !disp_slot && !host_gnt_q && blank_ok;
    // Next shift value is also the pixel source, so pixel x leaves one clock after h_count == x.
    sr_d = (h_count[2:0] == 3'd0) ? hold_q : {sr_q[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_gnt_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      is_disp_q     <= 1'b0;
      disp_pend_q   <= 1'b0;
      host_rvalid_q <= 1'b0;
      hold_q        <= '0;
      sr_q          <= '0;
      pixel_q       <= 1'b0;
      pixel_en_q    <= 1'b0;
    end else begin
      host_gnt_q <= host_gnt_d;
      if (disp_slot) begin
        mem_addr_q <= disp_addr;
        mem_re_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        is_disp_q  <= 1'b1;
      end else if (host_gnt_d) begin
        mem_addr_q  <= host_addr;
        mem_re_q    <= !host_we;
        mem_we_q    <= host_we;
        mem_wdata_q <= host_wdata;
        is_disp_q   <= 1'b0;
      end else begin
        mem_re_q  <= 1'b0;
        mem_we_q  <= 1'b0;
        is_disp_q <= 1'b0;
      end
      disp_pend_q   <= mem_re_q && is_disp_q;
      host_rvalid_q <= mem_re_q && !is_disp_q;
      if (disp_pend_q) hold_q <= mem_rdata;
      sr_q       <= sr_d;
      pixel_q    <= sr_d[7];
      pixel_en_q <= display_en;
    end
  end

  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rvalid_q ? mem_rdata : '0;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign pixel_o     = pixel_q;
  assign pixel_en_o  = pixel_en_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: bench drives the sync counters and models the SRAM.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count, v_count;
  logic        display_en;
  logic        pixel_o, pixel_en_o;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt, host_rvalid;
  logic [7:0]  host_rdata;
  logic [15:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        prev_gnt = 1'b0;
  int          fetch_ok = 0;

  vga_fb_arbiter #(
    .H_TOTAL(800), .H_DISPLAY(640), .V_TOTAL(525), .V_DISPLAY(480), .WORDS_PER_LINE(80)
  ) dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .pixel_o(pixel_o), .pixel_en_o(pixel_en_o),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM: strobes captured mid-cycle, read data presented in the following cycle.
  initial begin
    logic        pr;
    logic [15:0] pa;
    mem_rdata = '0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = '0;
    for (int y = 0; y < 480; y++)
      for (int k = 0; k < 80; k++) mem[y * 80 + k] = 8'(k ^ y);
    forever begin
      @(negedge clk);
      if (mem_we) mem[mem_addr] = mem_wdata;
      pr = mem_re;
      pa = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = pr ? mem[pa] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, h_count, v_count);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (h_count == 10'd799) begin
      h_count = '0;
      v_count = (v_count == 10'd524) ? '0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
    display_en = (h_count < 10'd640) && (v_count < 10'd480);
  endtask

  task automatic setpos(input int hh, input int vv);
    h_count    = 10'(hh);
    v_count    = 10'(vv);
    display_en = (h_count < 10'd640) && (v_count < 10'd480);
  endtask

  task automatic scan_checks();
    int hh, vv, tx, ty, x;
    logic [7:0] w;
    hh = int'(h_count);
    vv = int'(v_count);
    if (host_gnt) chk("gnt_b2b", 32'(prev_gnt), 32'd0);
    prev_gnt = host_gnt;
    if (hh % 8 == 2) begin
      tx = hh + 6;
      ty = vv;
      if (tx >= 800) begin
        tx -= 800;
        ty += 1;
        if (ty == 525) ty = 0;
      end
      if (tx < 640 && ty < 480) begin
        chk("disp_re", 32'(mem_re), 32'd1);
        chk("disp_addr", 32'(mem_addr), 32'(ty * 80 + tx / 8));
        chk("disp_nognt", 32'(host_gnt), 32'd0);
        if (mem_re && mem_addr == 16'(ty * 80 + tx / 8)) fetch_ok++;
      end
    end
    if (vv < 480 && hh >= 1 && hh <= 640) begin
      x = hh - 1;
      w = 8'((x / 8) ^ vv);
      chk("pix", 32'(pixel_o), 32'(w[7 - x % 8]));
      chk("pix_en", 32'(pixel_en_o), 32'd1);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      scan_checks();
      tick();
    end
  endtask

  task automatic host_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                             input int bound, output logic [7:0] rd, output int gh, output int gv);
    logic got;
    got = 1'b0;
    rd = '0;
    gh = -1;
    gv = -1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      scan_checks();
      if (host_gnt) begin
        got = 1'b1;
        gh = int'(h_count);
        gv = int'(v_count);
        chk("gnt_we", 32'(mem_we), 32'(we));
        chk("gnt_re", 32'(mem_re), 32'(!we));
        chk("gnt_addr", 32'(mem_addr), 32'(a));
        if (we) chk("gnt_wdata", 32'(mem_wdata), 32'(d));
      end
      tick();
      if (got) host_req = 1'b0;
    end
    host_req = 1'b0;
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    else if (!we) begin
      @(negedge clk);
      scan_checks();
      chk("rvalid", 32'(host_rvalid), 32'd1);
      rd = host_rdata;
      tick();
    end
  endtask

  initial begin
    logic [7:0] rd;
    int gh, gv;

    // Reset with a pending read request: nothing may leave the arbiter.
    reset = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0123; host_wdata = '0;
    setpos(0, 500);
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", 32'({host_gnt, mem_re, mem_we, pixel_o, host_rvalid}), 32'd0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rel_nognt", 32'(host_gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("first_gnt", 32'(host_gnt), 32'd1);
    chk("first_re", 32'(mem_re), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h0123);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("first_rvalid", 32'(host_rvalid), 32'd1);
    chk("first_rdata", 32'(host_rdata), 32'h30);
    tick();

    // Frame wrap: word 0 of line 0 fetched at the end of the last line, then line 0 scan.
    setpos(780, 524);
    run(14);
    @(negedge clk);
    chk("wrap_re", 32'(mem_re), 32'd1);
    chk("wrap_addr", 32'(mem_addr), 32'd0);
    scan_checks();
    tick();
    run(805);

    // Host write then read back during line 10.
    setpos(780, 9);
    run(120);
    host_access(1'b1, 16'h0123, 8'hA5, 700, rd, gh, gv);
    chk("sram_wr", 32'(mem[16'h0123]), 32'hA5);
    host_access(1'b0, 16'h0123, 8'h00, 700, rd, gh, gv);
    chk("rd_back", 32'(rd), 32'hA5);

    // Line 5 with a continuously held read request.
    setpos(780, 4);
    fetch_ok = 0;
    run(28);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200;
    repeat (692) begin
      @(negedge clk);
      scan_checks();
      if (h_count >= 10'd9 && h_count <= 10'd72) chk("gnt_pat", 32'(host_gnt), 32'(h_count[0]));
      if (h_count >= 10'd10 && h_count <= 10'd73) chk("rv_pat", 32'(host_rvalid), 32'(!h_count[0]));
      tick();
      if (h_count == 10'd74) host_req = 1'b0;
    end
    chk("fetches", 32'(fetch_ok), 32'd80);

    // Grant position for a request raised at (100, 50).
    setpos(780, 49);
    run(120);
    host_access(1'b1, 16'h0300, 8'h3C, 700, rd, gh, gv);
`ifdef VGA_FB_HOST_BLANK_ONLY_EN
    chk("gnt_h", 32'(gh), 32'd641);
`else
    chk("gnt_h", 32'(gh), 32'd101);
`endif
    chk("gnt_v", 32'(gv), 32'd50);
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
